// File: rtl/walking_shift_register.sv
// walking_shift_register: WIDTH-bit pattern register that can be loaded,
// cleared to an init pattern, or stepped one bit per cycle (left/right,
// rotate/shift-fill), with a modulo-WIDTH step counter and a wrap pulse.
// Optional feature macro: WALKER_PARITY_EN adds a registered o_PARITY output.
module walking_shift_register #(
    parameter int                 p_WIDTH     = 8,
    parameter logic [p_WIDTH-1:0] p_INIT_DATA = 1,
    // derived from p_WIDTH; leave at its default
    parameter int                 p_CNT_W     = $clog2(p_WIDTH)
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_CLEAR,
    input  logic               i_LOAD,
    input  logic [p_WIDTH-1:0] i_DIN,
    input  logic               i_SHIFT,
    input  logic               i_DIR,
    input  logic               i_MODE,
    input  logic               i_SERIAL_IN,
    output logic [p_WIDTH-1:0] o_DOUT,
    output logic               o_SERIAL_OUT,
    output logic [p_CNT_W-1:0] o_STEP,
    output logic               o_WRAP,
    output logic               o_ZERO
`ifdef WALKER_PARITY_EN
    ,
    output logic               o_PARITY
`endif
);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_SHIFT,
        OP_LOAD,
        OP_CLEAR
    } op_t;

    localparam logic [p_CNT_W-1:0] LAST_STEP = p_CNT_W'(p_WIDTH - 1);

    op_t                op;
    logic               fill;
    logic               shift_out;
    logic               last_step;
    logic [p_WIDTH-1:0] shifted;
    logic [p_WIDTH-1:0] next_dout;

    // Resolve control priority and form the next pattern value
    always_comb begin
        op        = OP_HOLD;
        fill      = i_SERIAL_IN;
        shifted   = o_DOUT;
        shift_out = o_SERIAL_OUT;
        next_dout = o_DOUT;

        if (i_CLEAR)
            op = OP_CLEAR;
        else if (i_LOAD)
            op = OP_LOAD;
        else if (i_SHIFT)
            op = OP_SHIFT;

        if (i_DIR) begin
            fill      = i_MODE ? o_DOUT[0] : i_SERIAL_IN;
            shifted   = {fill, o_DOUT[p_WIDTH-1:1]};
            shift_out = o_DOUT[0];
        end else begin
            fill      = i_MODE ? o_DOUT[p_WIDTH-1] : i_SERIAL_IN;
            shifted   = {o_DOUT[p_WIDTH-2:0], fill};
            shift_out = o_DOUT[p_WIDTH-1];
        end

        case (op)
            OP_CLEAR: next_dout = p_INIT_DATA;
            OP_LOAD:  next_dout = i_DIN;
            OP_SHIFT: next_dout = shifted;
            default:  next_dout = o_DOUT;
        endcase
    end

    assign last_step = (o_STEP == LAST_STEP);

    // Pattern, serial-out, step counter and wrap pulse registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_DOUT       <= p_INIT_DATA;
            o_SERIAL_OUT <= 1'b0;
            o_STEP       <= '0;
            o_WRAP       <= 1'b0;
        end else begin
            o_DOUT <= next_dout;
            case (op)
                OP_CLEAR, OP_LOAD: begin
                    o_SERIAL_OUT <= 1'b0;
                    o_STEP       <= '0;
                    o_WRAP       <= 1'b0;
                end
                OP_SHIFT: begin
                    o_SERIAL_OUT <= shift_out;
                    // explicit wrap at p_WIDTH-1 so non-power-of-2 widths count correctly
                    o_STEP       <= last_step ? '0 : o_STEP + p_CNT_W'(1);
                    o_WRAP       <= last_step;
                end
                default: begin
                    o_WRAP <= 1'b0;
                end
            endcase
        end
    end

`ifdef WALKER_PARITY_EN
    // Even parity of the value being written into the pattern register
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            o_PARITY <= ^p_INIT_DATA;
        else
            o_PARITY <= ^next_dout;
    end
`endif

    assign o_ZERO = (o_DOUT == '0);

endmodule

// File: tb/tb_walking_shift_register.sv
// Testbench for walking_shift_register: table-driven vectors on an 8-bit
// instance plus hand sequences for async reset, a 5-bit wrap and parity.
module tb_walking_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear, load, shift, dir, mode, sin;
    logic [7:0] din;

    logic [7:0] dout;
    logic       sout, wrap, zero;
    logic [2:0] step;

    logic [4:0] dout5;
    logic       sout5, wrap5, zero5;
    logic [2:0] step5;

`ifdef WALKER_PARITY_EN
    logic       par, par5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    walking_shift_register #(
        .p_WIDTH     (8),
        .p_INIT_DATA (8'h01)
    ) u_dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_CLEAR      (clear),
        .i_LOAD       (load),
        .i_DIN        (din),
        .i_SHIFT      (shift),
        .i_DIR        (dir),
        .i_MODE       (mode),
        .i_SERIAL_IN  (sin),
        .o_DOUT       (dout),
        .o_SERIAL_OUT (sout),
        .o_STEP       (step),
        .o_WRAP       (wrap),
        .o_ZERO       (zero)
`ifdef WALKER_PARITY_EN
        ,
        .o_PARITY     (par)
`endif
    );

    walking_shift_register #(
        .p_WIDTH     (5),
        .p_INIT_DATA (5'b00001)
    ) u_dut5 (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_CLEAR      (clear),
        .i_LOAD       (load),
        .i_DIN        (din[4:0]),
        .i_SHIFT      (shift),
        .i_DIR        (dir),
        .i_MODE       (mode),
        .i_SERIAL_IN  (sin),
        .o_DOUT       (dout5),
        .o_SERIAL_OUT (sout5),
        .o_STEP       (step5),
        .o_WRAP       (wrap5),
        .o_ZERO       (zero5)
`ifdef WALKER_PARITY_EN
        ,
        .o_PARITY     (par5)
`endif
    );

    typedef struct {
        logic       clear, load;
        logic [7:0] din;
        logic       shift, dir, mode, sin;
        logic [7:0] dout;
        logic [2:0] step;
        logic       wrap, sout, zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic l, logic [7:0] d, logic s, logic dr,
                                logic m, logic si, logic [7:0] ed, logic [2:0] es,
                                logic ew, logic eso, logic ez);
        vec_t v;
        v.clear = c;  v.load = l;  v.din = d;  v.shift = s;
        v.dir = dr;   v.mode = m;  v.sin = si;
        v.dout = ed;  v.step = es; v.wrap = ew; v.sout = eso; v.zero = ez;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [7:0] d, input logic s,
                         input logic dr, input logic m, input logic si);
        clear = c; load = l; din = d; shift = s; dir = dr; mode = m; sin = si;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // clr ld din sh dir mode sin | dout step wrap sout zero
        vecs.push_back(mk(0,0,8'h00,0,0,0,0, 8'h01,0,0,0,0));
        // rotate-left walk
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h02,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h04,2,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h08,3,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h10,4,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h20,5,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h40,6,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h80,7,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h01,0,1,1,0));
        vecs.push_back(mk(0,0,8'h00,0,0,1,0, 8'h01,0,0,1,0));
        // load then shift-right with zero fill
        vecs.push_back(mk(0,1,8'hF0,0,0,0,0, 8'hF0,0,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h78,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h3C,2,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h1E,3,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h0F,4,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h07,5,0,1,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h03,6,0,1,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h01,7,0,1,0));
        vecs.push_back(mk(0,0,8'h00,1,1,0,0, 8'h00,0,1,1,1));
        vecs.push_back(mk(0,0,8'h00,0,1,0,0, 8'h00,0,0,1,1));
        // shift-left with one fill
        vecs.push_back(mk(0,0,8'h00,1,0,0,1, 8'h01,1,0,0,0));
        // priority: clear beats load and shift, load beats shift
        vecs.push_back(mk(1,1,8'hAA,1,0,1,0, 8'h01,0,0,0,0));
        vecs.push_back(mk(0,1,8'hAA,1,0,1,0, 8'hAA,0,0,0,0));
        // rotate right
        vecs.push_back(mk(0,0,8'h00,1,1,1,0, 8'h55,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,1,1,0, 8'hAA,2,0,1,0));
        // clear, then a full walk with shift held past the wrap
        vecs.push_back(mk(1,0,8'h00,0,0,0,0, 8'h01,0,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h02,1,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h04,2,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h08,3,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h10,4,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h20,5,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h40,6,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h80,7,0,0,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h01,0,1,1,0));
        vecs.push_back(mk(0,0,8'h00,1,0,1,0, 8'h02,1,0,0,0));
        // dir/mode/serial-in are ignored without a shift
        vecs.push_back(mk(0,0,8'h00,0,1,0,1, 8'h02,1,0,0,0));

        rst = 1'b1;
        drive(0,0,8'h00,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset.dout", 32'(dout), 32'h01);
        check("reset.step", 32'(step), 32'd0);
        check("reset.wrap", 32'(wrap), 32'd0);
        check("reset.sout", 32'(sout), 32'd0);
        check("reset.zero", 32'(zero), 32'd0);
`ifdef WALKER_PARITY_EN
        check("reset.parity", 32'(par), 32'd1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clear, vecs[i].load, vecs[i].din, vecs[i].shift,
                  vecs[i].dir, vecs[i].mode, vecs[i].sin);
            step_clk();
            check($sformatf("v%0d.dout", i), 32'(dout), 32'(vecs[i].dout));
            check($sformatf("v%0d.step", i), 32'(step), 32'(vecs[i].step));
            check($sformatf("v%0d.wrap", i), 32'(wrap), 32'(vecs[i].wrap));
            check($sformatf("v%0d.sout", i), 32'(sout), 32'(vecs[i].sout));
            check($sformatf("v%0d.zero", i), 32'(zero), 32'(vecs[i].zero));
        end

        // async reset mid-walk: 5 rotate steps, then reset between edges
        drive(1,0,8'h00,0,0,0,0);
        step_clk();
        drive(0,0,8'h00,1,0,1,0);
        repeat (5) step_clk();
        check("midwalk.dout", 32'(dout), 32'h20);
        check("midwalk.step", 32'(step), 32'd5);
        drive(0,0,8'h00,0,0,0,0);
        #3;
        rst = 1'b1;
        #1;
        check("async.dout", 32'(dout), 32'h01);
        check("async.step", 32'(step), 32'd0);
        check("async.wrap", 32'(wrap), 32'd0);
        #1;
        rst = 1'b0;
        step_clk();
        check("postrst.dout", 32'(dout), 32'h01);
        check("postrst.wrap", 32'(wrap), 32'd0);

        // non-power-of-2 width wraps after 5 steps, not 8
        drive(1,0,8'h00,0,0,0,0);
        step_clk();
        drive(0,0,8'h00,1,0,1,0);
        step_clk(); check("w5.s1.step", 32'(step5), 32'd1); check("w5.s1.dout", 32'(dout5), 32'h02);
        step_clk(); check("w5.s2.step", 32'(step5), 32'd2);
        step_clk(); check("w5.s3.step", 32'(step5), 32'd3);
        step_clk(); check("w5.s4.step", 32'(step5), 32'd4); check("w5.s4.wrap", 32'(wrap5), 32'd0);
        check("w5.s4.dout", 32'(dout5), 32'h10);
        step_clk(); check("w5.s5.step", 32'(step5), 32'd0); check("w5.s5.wrap", 32'(wrap5), 32'd1);
        check("w5.s5.dout", 32'(dout5), 32'h01); check("w5.s5.sout", 32'(sout5), 32'd1);
        check("w5.s5.zero", 32'(zero5), 32'd0);
        step_clk(); check("w5.s6.step", 32'(step5), 32'd1); check("w5.s6.wrap", 32'(wrap5), 32'd0);

`ifdef WALKER_PARITY_EN
        drive(0,1,8'h07,0,0,0,0);
        step_clk(); check("par.load07", 32'(par), 32'd1);
        drive(0,0,8'h00,1,0,1,0);
        step_clk(); check("par.rot0E", 32'(par), 32'd1); check("par.dout0E", 32'(dout), 32'h0E);
        drive(0,1,8'h03,0,0,0,0);
        step_clk(); check("par.load03", 32'(par), 32'd0);
        drive(1,0,8'h00,0,0,0,0);
        step_clk(); check("par.clear", 32'(par), 32'd1);
`endif

        drive(0,0,8'h00,0,0,0,0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
